// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle MIPS datapath.
// Sequences the PC/IR/MDR/A-B/ALUOut register enables, register-file write,
// memory read/write handshake and the ALU/PC source selects, one state per
// datapath cycle.
// Ports:
//   Clock, Reset_n          clock, asynchronous active-low reset
//   Opcode, Funct           IR[31:26], IR[5:0]
//   Zero, MemReady          ALU zero flag, memory completion
//   *Enable, RegWrite       datapath register / register-file strobes
//   MemRead, MemWrite, IorD memory request and address select
//   ALUSrcB, ALUOp, PCSource, RegDst, MemToReg  datapath selects
//   State, Halted, Trap     debug state, halt flag, sticky trap cause
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEnable,
  output logic       IREnable,
  output logic       MDREnable,
  output logic       ABEnable,
  output logic       ALUOutEnable,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [3:0] State,
  output logic       Halted,
  output logic [1:0] Trap
);

  localparam int unsigned CntW = 8;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] FnSys   = 6'h0C;

  localparam logic [1:0] TrapNone    = 2'd0;
  localparam logic [1:0] TrapIllegal = 2'd1;
  localparam logic [1:0] TrapBus     = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_WBALU  = 4'd5,
    S_WBMEM  = 4'd6,
    S_HALT   = 4'd7,
    S_TRAP   = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_LW, C_SW, C_BEQ, C_J, C_ADDI, C_SYS, C_ILL
  } iclass_e;

  state_e            state_q, state_d;
  iclass_e           class_q, class_d, dec_class;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        trap_q, trap_d;
  logic              mem_wait;
  logic              timeout;

  // Instruction class decoded from the live IR fields (used only in DECODE).
  always_comb begin
    case (Opcode)
      OpRtype: dec_class = (Funct == FnSys) ? C_SYS : C_RTYPE;
      OpLw:    dec_class = C_LW;
      OpSw:    dec_class = C_SW;
      OpBeq:   dec_class = C_BEQ;
      OpJ:     dec_class = C_J;
      OpAddi:  dec_class = C_ADDI;
      default: dec_class = C_ILL;
    endcase
  end

  assign timeout = (cnt_q == CntW'(MEM_TIMEOUT));

  // State, class, wait counter and trap cause registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_FETCH;
      class_q <= C_RTYPE;
      cnt_q   <= '0;
      trap_q  <= TrapNone;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  // Next-state and Mealy output decode.
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    trap_d       = trap_q;
    mem_wait     = 1'b0;
    PCEnable     = 1'b0;
    IREnable     = 1'b0;
    MDREnable    = 1'b0;
    ABEnable     = 1'b0;
    ALUOutEnable = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    ALUSrcB      = 2'd0;
    ALUOp        = 2'd0;
    PCSource     = 2'd0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        if (MemReady) begin
          IREnable = 1'b1;
          PCEnable = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = TrapBus;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while A/B load.
        ABEnable     = 1'b1;
        ALUOutEnable = 1'b1;
        ALUSrcB      = 2'd3;
        class_d      = dec_class;
        case (dec_class)
          C_SYS:   state_d = S_HALT;
          C_ILL: begin
            state_d = S_TRAP;
            trap_d  = TrapIllegal;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (class_q)
          C_RTYPE: begin
            ALUOp        = 2'd2;
            ALUOutEnable = 1'b1;
            state_d      = S_WBALU;
          end
          C_ADDI, C_LW, C_SW: begin
            ALUSrcB      = 2'd2;
            ALUOutEnable = 1'b1;
            if (class_q == C_ADDI)    state_d = S_WBALU;
            else if (class_q == C_LW) state_d = S_MEMRD;
            else                      state_d = S_MEMWR;
          end
          C_BEQ: begin
            ALUOp    = 2'd1;
            PCSource = 2'd1;
            PCEnable = Zero;
            state_d  = S_FETCH;
          end
          C_J: begin
            PCSource = 2'd2;
            PCEnable = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          MDREnable = 1'b1;
          state_d   = S_WBMEM;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = TrapBus;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = TrapBus;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_WBALU: begin
        RegWrite = 1'b1;
        RegDst   = (class_q == C_RTYPE);
        state_d  = S_FETCH;
      end
      S_WBMEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT, S_TRAP: begin
        state_d = state_q;
      end
      default: state_d = S_FETCH;
    endcase

    // While reset is held the FSM sits in FETCH; suppress its strobes so a
    // ready memory cannot pulse the PC/IR during reset.
    if (!Reset_n) begin
      PCEnable     = 1'b0;
      IREnable     = 1'b0;
      MDREnable    = 1'b0;
      ABEnable     = 1'b0;
      ALUOutEnable = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
    end

    // Counter measures wait cycles spent in the current state only.
    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + CntW'(1);
    else                    cnt_d = cnt_q;
  end

  assign State  = state_q;
  assign Halted = (state_q == S_HALT);
  assign Trap   = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: walks each instruction through
// the per-cycle phase list it should take, with randomized memory waits.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 4;

  // Instruction kinds used by the bench
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5;

  // Expected enable vectors {PCE,IRE,MDRE,ABE,ALUOE,RegWrite,MemRead,MemWrite}
  localparam logic [7:0] EN_NONE = 8'b0000_0000;
  localparam logic [7:0] EN_FW   = 8'b0000_0010;
  localparam logic [7:0] EN_FR   = 8'b1100_0010;
  localparam logic [7:0] EN_DEC  = 8'b0001_1000;
  localparam logic [7:0] EN_ALU  = 8'b0000_1000;
  localparam logic [7:0] EN_J    = 8'b1000_0000;
  localparam logic [7:0] EN_MRW  = 8'b0000_0010;
  localparam logic [7:0] EN_MRR  = 8'b0010_0010;
  localparam logic [7:0] EN_MW   = 8'b0000_0001;
  localparam logic [7:0] EN_WB   = 8'b0000_0100;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic       PCEnable, IREnable, MDREnable, ABEnable, ALUOutEnable;
  logic       RegWrite, MemRead, MemWrite, IorD;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       RegDst, MemToReg;
  logic [3:0] State;
  logic       Halted;
  logic [1:0] Trap;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady),
    .PCEnable(PCEnable), .IREnable(IREnable), .MDREnable(MDREnable),
    .ABEnable(ABEnable), .ALUOutEnable(ALUOutEnable), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .RegDst(RegDst), .MemToReg(MemToReg),
    .State(State), .Halted(Halted), .Trap(Trap)
  );

  function automatic logic [7:0] en_obs();
    return {PCEnable, IREnable, MDREnable, ABEnable, ALUOutEnable,
            RegWrite, MemRead, MemWrite};
  endfunction

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_LW:    return 6'h23;
      K_SW:    return 6'h2B;
      K_BEQ:   return 6'h04;
      K_J:     return 6'h02;
      K_ADDI:  return 6'h08;
      default: return 6'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive MemReady, settle, check state and strobes.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] est,
                     input logic [7:0] een);
    MemReady = mr;
    #1;
    chk({tag, ".state"}, 8'(State), 8'(est));
    chk({tag, ".en"}, en_obs(), een);
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset_n  = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("rst.state", 8'(State), 8'd0);
    chk("rst.en", en_obs(), EN_FW);
    chk("rst.trap", 8'(Trap), 8'd0);
    chk("rst.halted", 8'(Halted), 8'd0);
    tick();
    Reset_n = 1'b1;
  endtask

  // One instruction: wf wait cycles in FETCH, wm wait cycles in MEMRD/MEMWR.
  task automatic run_instr(input string nm, input int k, input logic z,
                           input int wf, input int wm);
    logic [5:0] fn;
    logic [7:0] ee;
    fn = 6'($urandom);
    if (k == K_R || fn == 6'h0C) fn = 6'h20;
    Opcode = op_of(k);
    Funct  = fn;
    Zero   = z;
    for (int w = 0; w < wf; w++) begin
      cyc({nm, ".fwait"}, 1'b0, 4'd0, EN_FW);
      tick();
    end
    cyc({nm, ".fetch"}, 1'b1, 4'd0, EN_FR);
    chk({nm, ".fetch.sel"}, {1'b0, IorD, ALUSrcB, ALUOp, PCSource},
        {1'b0, 1'b0, 2'd1, 2'd0, 2'd0});
    tick();
    cyc({nm, ".decode"}, 1'($urandom), 4'd1, EN_DEC);
    chk({nm, ".decode.sel"}, 8'({ALUSrcB, ALUOp}), 8'({2'd3, 2'd0}));
    tick();
    // Scramble the live IR fields: later states must use the captured class.
    Opcode = 6'($urandom);
    Funct  = 6'($urandom);
    case (k)
      K_BEQ:   ee = {z, 7'b0};
      K_J:     ee = EN_J;
      default: ee = EN_ALU;
    endcase
    cyc({nm, ".exec"}, 1'($urandom), 4'd2, ee);
    case (k)
      K_R:     chk({nm, ".exec.sel"}, 8'({ALUSrcB, ALUOp}), 8'({2'd0, 2'd2}));
      K_BEQ:   chk({nm, ".exec.sel"}, 8'({ALUSrcB, ALUOp, PCSource}), 8'({2'd0, 2'd1, 2'd1}));
      K_J:     chk({nm, ".exec.sel"}, 8'(PCSource), 8'd2);
      default: chk({nm, ".exec.sel"}, 8'({ALUSrcB, ALUOp}), 8'({2'd2, 2'd0}));
    endcase
    tick();
    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w < wm; w++) begin
        cyc({nm, ".mwait"}, 1'b0, (k == K_LW) ? 4'd3 : 4'd4,
            (k == K_LW) ? EN_MRW : EN_MW);
        chk({nm, ".mwait.iord"}, 8'(IorD), 8'd1);
        tick();
      end
      cyc({nm, ".mem"}, 1'b1, (k == K_LW) ? 4'd3 : 4'd4,
          (k == K_LW) ? EN_MRR : EN_MW);
      chk({nm, ".mem.iord"}, 8'(IorD), 8'd1);
      tick();
    end
    if (k == K_LW) begin
      cyc({nm, ".wbmem"}, 1'($urandom), 4'd6, EN_WB);
      chk({nm, ".wbmem.sel"}, 8'({RegDst, MemToReg}), 8'b01);
      tick();
    end
    if (k == K_R || k == K_ADDI) begin
      cyc({nm, ".wbalu"}, 1'($urandom), 4'd5, EN_WB);
      chk({nm, ".wbalu.sel"}, 8'({RegDst, MemToReg}), 8'({k == K_R, 1'b0}));
      tick();
    end
    #1;
    chk({nm, ".end.state"}, 8'(State), 8'd0);
    chk({nm, ".end.trap"}, 8'({Halted, Trap}), 8'd0);
  endtask

  // Terminal-state hold: state and cause stay, every strobe stays low.
  task automatic hold_terminal(input string nm, input logic [3:0] est,
                               input logic [1:0] etrap, input logic ehalt);
    for (int i = 0; i < 10; i++) begin
      Opcode = 6'($urandom);
      Zero   = 1'($urandom);
      cyc(nm, 1'($urandom), est, EN_NONE);
      chk({nm, ".trap"}, 8'(Trap), 8'(etrap));
      chk({nm, ".halted"}, 8'(Halted), 8'(ehalt));
      tick();
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    Opcode   = 6'h00;
    Funct    = 6'h00;
    Zero     = 1'b0;
    MemReady = 1'b1;
    @(negedge Clock);
    do_reset();

    // Directed instruction mix with MemReady mostly tied high
    run_instr("lw", K_LW, 1'b0, 0, 0);
    run_instr("radd", K_R, 1'b0, 0, 0);
    run_instr("beq1", K_BEQ, 1'b1, 0, 0);
    run_instr("beq0", K_BEQ, 1'b0, 0, 0);
    run_instr("j", K_J, 1'b0, 0, 0);
    run_instr("addi", K_ADDI, 1'b0, 0, 0);
    run_instr("sw3", K_SW, 1'b0, 0, 3);
    // Ready arriving exactly at the wait limit completes without trapping
    run_instr("lwmax", K_LW, 1'b0, TMO, TMO);
    run_instr("swmax", K_SW, 1'b1, TMO, TMO);

    // Randomized instruction stream
    for (int i = 0; i < 30; i++) begin
      run_instr("rnd", $urandom_range(0, 5), 1'($urandom),
                $urandom_range(0, TMO), $urandom_range(0, TMO));
    end

    // Reset in the middle of an lw's MEMRD
    Opcode = 6'h23;
    cyc("rmid.fetch", 1'b1, 4'd0, EN_FR); tick();
    cyc("rmid.decode", 1'b1, 4'd1, EN_DEC); tick();
    cyc("rmid.exec", 1'b1, 4'd2, EN_ALU); tick();
    cyc("rmid.memrd", 1'b0, 4'd3, EN_MRW);
    MemReady = 1'b1;
    Reset_n  = 1'b0;
    #1;
    chk("rmid.state", 8'(State), 8'd0);
    chk("rmid.en", en_obs(), EN_FW);
    tick();
    Reset_n = 1'b1;
    run_instr("rmid.lw", K_LW, 1'b0, 0, 0);

    // Fetch timeout: MemReady stuck low
    Opcode = 6'h23;
    for (int w = 0; w <= int'(TMO); w++) begin
      cyc("tmo.fetch", 1'b0, 4'd0, EN_FW);
      tick();
    end
    hold_terminal("tmo.hold", 4'd8, 2'd2, 1'b0);
    do_reset();

    // Read timeout inside MEMRD
    Opcode = 6'h23;
    cyc("tmor.fetch", 1'b1, 4'd0, EN_FR); tick();
    cyc("tmor.decode", 1'b1, 4'd1, EN_DEC); tick();
    cyc("tmor.exec", 1'b1, 4'd2, EN_ALU); tick();
    for (int w = 0; w <= int'(TMO); w++) begin
      cyc("tmor.memrd", 1'b0, 4'd3, EN_MRW);
      tick();
    end
    hold_terminal("tmor.hold", 4'd8, 2'd2, 1'b0);
    do_reset();

    // Illegal opcode
    Opcode = 6'h3F;
    cyc("ill.fetch", 1'b1, 4'd0, EN_FR); tick();
    cyc("ill.decode", 1'b1, 4'd1, EN_DEC); tick();
    hold_terminal("ill.hold", 4'd8, 2'd1, 1'b0);
    do_reset();

    // syscall halts
    Opcode = 6'h00;
    Funct  = 6'h0C;
    cyc("sys.fetch", 1'b1, 4'd0, EN_FR); tick();
    cyc("sys.decode", 1'b1, 4'd1, EN_DEC); tick();
    hold_terminal("sys.hold", 4'd7, 2'd0, 1'b1);
    do_reset();
    run_instr("post", K_ADDI, 1'b0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
